// File: rtl/nms_frame_arbiter_pkg.sv
// Shared definitions for the NMS frame arbiter: FSM encoding and the
// packed {Dir, Mag} beat layout carried on the 16-bit stream.
package nms_frame_arbiter_pkg;

  localparam int BEAT_W  = 16;
  localparam int MAG_LSB = 0;
  localparam int MAG_MSB = 11;
  localparam int DIR_LSB = 12;
  localparam int DIR_MSB = 14;
  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS  = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [BEAT_W-1:0] data;
    logic              user;
    logic              last;
    logic              valid;
  } beat_t;

  function automatic beat_t mk_beat(input logic [BEAT_W-1:0] data, input logic user,
                                    input logic last, input logic valid);
    beat_t b;
    b.data  = data;
    b.user  = user;
    b.last  = last;
    b.valid = valid;
    return b;
  endfunction

endpackage

// File: rtl/nms_drain_monitor.sv
// Watches the NMS stage output while the arbiter drains a frame: counts
// returned lines and flags a stalled pipeline after DRAIN_TIMEOUT idle cycles.
module nms_drain_monitor #(
  parameter int OUT_LINES     = 1079,
  parameter int DRAIN_TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic active,
  input  logic mon_tvalid,
  input  logic mon_tready,
  input  logic mon_tlast,
  output logic done,
  output logic timeout
);

  localparam int LW = $clog2(OUT_LINES + 1);
  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);

  logic [LW-1:0] line_cnt;
  logic [TW-1:0] idle_cnt;
  logic          hs, eol;

  assign hs  = mon_tvalid & mon_tready;
  assign eol = hs & mon_tlast;

  // Terminal conditions are decoded one count early so the FSM leaves
  // DRAIN exactly on the cycle the limit is reached.
  assign done    = active & eol & (line_cnt == LW'(OUT_LINES - 1));
  assign timeout = active & ~hs & (idle_cnt == TW'(DRAIN_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_cnt <= '0;
      idle_cnt <= '0;
    end else if (clear) begin
      line_cnt <= '0;
      idle_cnt <= '0;
    end else if (active) begin
      if (eol && line_cnt != LW'(OUT_LINES))
        line_cnt <= line_cnt + LW'(1);
      if (hs)
        idle_cnt <= '0;
      else if (idle_cnt != TW'(DRAIN_TIMEOUT))
        idle_cnt <= idle_cnt + TW'(1);
    end
  end

endmodule

// File: rtl/nms_frame_arbiter.sv
// Two-requester frame arbiter in front of the NMS stage: grants whole frames
// round-robin on SOF, forwards with zero latency, then waits for the stage to drain.
module nms_frame_arbiter
  import nms_frame_arbiter_pkg::*;
#(
  parameter int IMG_WIDTH     = 1920,
  parameter int IMG_HEIGHT    = 1080,
  parameter int OUT_LINES     = IMG_HEIGHT - 1,
  parameter int DRAIN_TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BEAT_W-1:0] s0_tdata,
  input  logic              s0_tvalid,
  input  logic              s0_tuser,
  input  logic              s0_tlast,
  output logic              s0_tready,
  input  logic [BEAT_W-1:0] s1_tdata,
  input  logic              s1_tvalid,
  input  logic              s1_tuser,
  input  logic              s1_tlast,
  output logic              s1_tready,
  output logic [BEAT_W-1:0] m_tdata,
  output logic              m_tvalid,
  output logic              m_tuser,
  output logic              m_tlast,
  input  logic              m_tready,
  input  logic              mon_tvalid,
  input  logic              mon_tready,
  input  logic              mon_tlast,
  output logic              grant_id,
  output logic              busy,
  output logic              frame_done,
  output logic              err_sof,
  output logic              err_timeout,
  input  logic              err_clr
);

  localparam int LCW = $clog2(IMG_HEIGHT + 1);

  if (IMG_WIDTH < 1 || IMG_HEIGHT < 1 || OUT_LINES < 1 || DRAIN_TIMEOUT < 1) begin : g_bad_params
    $error("nms_frame_arbiter: all geometry parameters must be positive");
  end

  arb_state_t   state;
  logic         last_grant;
  logic         first_beat;
  logic [LCW-1:0] line_cnt, line_nxt;

  beat_t [NUM_REQ-1:0] req_beat;
  beat_t               sel;
  logic  [NUM_REQ-1:0] req;
  logic                grant_nxt, in_idle, in_pass, acc, restart, frame_end;
  logic                drain_clr, drain_done, drain_to;

  assign req_beat[0] = mk_beat(s0_tdata, s0_tuser, s0_tlast, s0_tvalid);
  assign req_beat[1] = mk_beat(s1_tdata, s1_tuser, s1_tlast, s1_tvalid);

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_req
    assign req[r] = req_beat[r].valid & req_beat[r].user;
  end

  assign in_idle   = (state == ST_IDLE);
  assign in_pass   = (state == ST_PASS);
  assign grant_nxt = (req[0] & req[1]) ? ~last_grant : req[1];
  assign sel       = req_beat[grant_id];

  assign m_tvalid = in_pass & sel.valid;
  assign m_tdata  = in_pass ? sel.data : '0;
  assign m_tuser  = in_pass & sel.user;
  assign m_tlast  = in_pass & sel.last;

  // IDLE sinks stray non-SOF beats so a requester that joined mid-frame
  // cannot block the port; rst_n gates ready so nothing is consumed in reset.
  assign s0_tready = rst_n & ((in_idle & ~s0_tuser) | (in_pass & ~grant_id & m_tready));
  assign s1_tready = rst_n & ((in_idle & ~s1_tuser) | (in_pass &  grant_id & m_tready));

  assign acc     = m_tvalid & m_tready;
  assign restart = acc & m_tuser & ~first_beat;

  // A mid-frame SOF restarts the line count; its own EOL counts as line 1.
  always_comb begin
    line_nxt = restart ? '0 : line_cnt;
    if (acc && m_tlast && line_nxt != LCW'(IMG_HEIGHT))
      line_nxt = line_nxt + LCW'(1);
  end

  assign frame_end = acc & m_tlast & (line_nxt == LCW'(IMG_HEIGHT));
  assign drain_clr = in_idle & (|req);
  assign busy      = ~in_idle;

  nms_drain_monitor #(
    .OUT_LINES    (OUT_LINES),
    .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
  ) u_drain (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (drain_clr),
    .active    (state == ST_DRAIN),
    .mon_tvalid(mon_tvalid),
    .mon_tready(mon_tready),
    .mon_tlast (mon_tlast),
    .done      (drain_done),
    .timeout   (drain_to)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      last_grant  <= 1'b1;
      grant_id    <= 1'b0;
      first_beat  <= 1'b0;
      line_cnt    <= '0;
      frame_done  <= 1'b0;
      err_sof     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      err_sof     <= restart  | (err_sof & ~err_clr);
      err_timeout <= drain_to | (err_timeout & ~err_clr);
      case (state)
        ST_IDLE: if (|req) begin
          state      <= ST_PASS;
          grant_id   <= grant_nxt;
          line_cnt   <= '0;
          first_beat <= 1'b1;
        end
        ST_PASS: if (acc) begin
          first_beat <= 1'b0;
          line_cnt   <= line_nxt;
          if (frame_end) state <= ST_DRAIN;
        end
        ST_DRAIN: if (drain_done || drain_to) begin
          state      <= ST_IDLE;
          frame_done <= 1'b1;
          last_grant <= grant_id;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
